// File: rtl/rf_pkg.sv
// Shared constants and types for the multi-port register file with scoreboard.
// Holds the default geometry (XLEN, NREGS, NRD, SP_IDX, SP_INIT) and the
// INIT/RUN state encoding used by the init sweep sequencer.
package rf_pkg;

  localparam int          RF_XLEN    = 32;
  localparam int          RF_NREGS   = 32;
  localparam int          RF_NRD     = 2;
  localparam int          RF_SP_IDX  = 2;
  localparam logic [31:0] RF_SP_INIT = 32'h2ffc;

  typedef enum logic {
    RF_INIT = 1'b0,
    RF_RUN  = 1'b1
  } rf_state_e;

endpackage

// File: rtl/rf_init_seq.sv
// Init sweep sequencer for the register file.
// After reset is released it walks every register index once, presenting a
// write of 0 (or SP_INIT at SP_IDX) per clock, then moves to RUN and raises
// ready. Reset from any state restarts the sweep.
// Ports:
//   clk        in   rising-edge clock
//   reset      in   synchronous, active-high reset
//   init_we    out  sweep write strobe (high in INIT while reset is low)
//   init_addr  out  register being initialised this cycle
//   init_data  out  value written to init_addr
//   ready      out  registered, high once the sweep has completed
module rf_init_seq
  import rf_pkg::*;
#(
  parameter int              XLEN    = RF_XLEN,
  parameter int              NREGS   = RF_NREGS,
  parameter int              SP_IDX  = RF_SP_IDX,
  parameter logic [XLEN-1:0] SP_INIT = XLEN'(RF_SP_INIT),
  localparam int             AW      = $clog2(NREGS)
) (
  input  logic            clk,
  input  logic            reset,
  output logic            init_we,
  output logic [AW-1:0]   init_addr,
  output logic [XLEN-1:0] init_data,
  output logic            ready
);

  localparam logic [AW-1:0] SP_ADDR   = AW'(SP_IDX);
  localparam logic [AW-1:0] LAST_ADDR = AW'(NREGS - 1);

  rf_state_e     r_state;
  logic [AW-1:0] r_cnt;
  logic          r_ready;

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values, independent of statement order.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state <= RF_INIT;
      r_cnt   <= '0;
      r_ready <= 1'b0;
    end else if (r_state == RF_INIT) begin
      r_cnt <= r_cnt + AW'(1);
      // The edge that initialises the last register completes the sweep.
      if (r_cnt == LAST_ADDR) begin
        r_state <= RF_RUN;
        r_ready <= 1'b1;
      end
    end
  end

  // The sweep write must not land on the edge where reset is sampled.
  assign init_we   = (r_state == RF_INIT) && !reset;
  assign init_addr = r_cnt;
  assign init_data = (r_cnt == SP_ADDR) ? SP_INIT : '0;
  assign ready     = r_ready;

endmodule

// File: rtl/regfile_mp_sb.sv
// Multi-read-port integer register file with a per-register busy scoreboard
// and a sequenced init sweep, for the multi-cycle RISC-V datapath.
// Optional feature: define RF_BYPASS_EN for write-through forwarding of the
// same-cycle write onto matching read ports.
// Ports:
//   clk         in   rising-edge clock
//   reset       in   synchronous, active-high reset (restarts init sweep)
//   rd_addr     in   NRD packed read addresses, port k at [k*AW +: AW]
//   rd_data     out  NRD packed read data, port k at [k*XLEN +: XLEN]
//   wr_en       in   writeback enable
//   wr_addr     in   writeback destination register
//   wr_data     in   writeback data
//   claim_en    in   mark claim_addr as having a pending write
//   claim_addr  in   register to mark busy
//   busy        out  scoreboard, bit i high while register i is pending
//   ready       out  high once the init sweep has completed
module regfile_mp_sb
  import rf_pkg::*;
#(
  parameter int              XLEN    = RF_XLEN,
  parameter int              NREGS   = RF_NREGS,
  parameter int              NRD     = RF_NRD,
  parameter int              SP_IDX  = RF_SP_IDX,
  parameter logic [XLEN-1:0] SP_INIT = XLEN'(RF_SP_INIT),
  localparam int             AW      = $clog2(NREGS)
) (
  input  logic                clk,
  input  logic                reset,
  input  logic [NRD*AW-1:0]   rd_addr,
  output logic [NRD*XLEN-1:0] rd_data,
  input  logic                wr_en,
  input  logic [AW-1:0]       wr_addr,
  input  logic [XLEN-1:0]     wr_data,
  input  logic                claim_en,
  input  logic [AW-1:0]       claim_addr,
  output logic [NREGS-1:0]    busy,
  output logic                ready
);

  logic            w_init_we;
  logic [AW-1:0]   w_init_addr;
  logic [XLEN-1:0] w_init_data;
  logic            w_ready;
  logic            w_wr_ok;
  logic            w_claim_ok;

  logic [XLEN-1:0] r_rf [NREGS];
  logic [NREGS-1:0] r_busy;

  rf_init_seq #(
    .XLEN    (XLEN),
    .NREGS   (NREGS),
    .SP_IDX  (SP_IDX),
    .SP_INIT (SP_INIT)
  ) u_init_seq (
    .clk       (clk),
    .reset     (reset),
    .init_we   (w_init_we),
    .init_addr (w_init_addr),
    .init_data (w_init_data),
    .ready     (w_ready)
  );

  // Normal traffic only counts in RUN and never on a reset edge; x0 is never
  // a real destination.
  assign w_wr_ok    = w_ready && !reset && wr_en && (wr_addr != '0);
  assign w_claim_ok = w_ready && !reset && claim_en && (claim_addr != '0);

  // NOTE: the storage array has no reset branch; it is cleared by the init
  // sweep instead, which keeps it mappable to plain RAM/flop arrays without a
  // wide reset fan-out.
  always_ff @(posedge clk) begin
    if (w_init_we) begin
      r_rf[w_init_addr] <= w_init_data;
    end else if (w_wr_ok) begin
      r_rf[wr_addr] <= wr_data;
    end
  end

  // Clear-then-set ordering: when the same register is written and claimed in
  // one cycle, the later assignment (the new producer's claim) wins.
  always_ff @(posedge clk) begin
    if (reset || !w_ready) begin
      r_busy <= '0;
    end else begin
      if (w_wr_ok) begin
        r_busy[wr_addr] <= 1'b0;
      end
      if (w_claim_ok) begin
        r_busy[claim_addr] <= 1'b1;
      end
    end
  end

  // NOTE: combinational read logic assigns a default first so no path can
  // leave rd_data unassigned and infer a latch.
  always_comb begin
    rd_data = '0;
    for (int k = 0; k < NRD; k++) begin
      if (w_ready && (rd_addr[k*AW +: AW] != '0)) begin
        rd_data[k*XLEN +: XLEN] = r_rf[rd_addr[k*AW +: AW]];
`ifdef RF_BYPASS_EN
        if (w_wr_ok && (rd_addr[k*AW +: AW] == wr_addr)) begin
          rd_data[k*XLEN +: XLEN] = wr_data;
        end
`endif
      end
    end
  end

  assign busy  = r_busy;
  assign ready = w_ready;

endmodule

// File: tb/tb_regfile_mp_sb.sv
// Self-checking bench for regfile_mp_sb: init sweep timing, reset mid-sweep,
// ignored traffic during INIT, a table of RUN-mode read/write/scoreboard
// vectors, the same-cycle bypass case, and randomized traffic checked
// against a behavioural model.
module tb_regfile_mp_sb;
  import rf_pkg::*;

  localparam int          XLEN    = 32;
  localparam int          NREGS   = 32;
  localparam int          NRD     = 2;
  localparam int          AW      = 5;
  localparam int          SP_IDX  = 2;
  localparam logic [31:0] SP_INIT = 32'h2ffc;

  logic                clk = 1'b0;
  logic                reset;
  logic [NRD*AW-1:0]   rd_addr;
  logic [NRD*XLEN-1:0] rd_data;
  logic                wr_en;
  logic [AW-1:0]       wr_addr;
  logic [XLEN-1:0]     wr_data;
  logic                claim_en;
  logic [AW-1:0]       claim_addr;
  logic [NREGS-1:0]    busy;
  logic                ready;

  always #5 clk = ~clk;

  regfile_mp_sb #(
    .XLEN    (XLEN),
    .NREGS   (NREGS),
    .NRD     (NRD),
    .SP_IDX  (SP_IDX),
    .SP_INIT (SP_INIT)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .rd_addr    (rd_addr),
    .rd_data    (rd_data),
    .wr_en      (wr_en),
    .wr_addr    (wr_addr),
    .wr_data    (wr_data),
    .claim_en   (claim_en),
    .claim_addr (claim_addr),
    .busy       (busy),
    .ready      (ready)
  );

  int n_total = 0;
  int n_bad   = 0;

  // Behavioural model: plain array contents, busy set, and how many
  // registers the sweep has covered since reset was released.
  logic [XLEN-1:0]  m_rf [NREGS];
  logic [NREGS-1:0] m_busy;
  bit               m_ready;
  int               m_swept;

  typedef struct {
    logic            we;
    logic [AW-1:0]   wa;
    logic [XLEN-1:0] wd;
    logic            ce;
    logic [AW-1:0]   ca;
    logic [AW-1:0]   ra0;
    logic [AW-1:0]   ra1;
    logic [XLEN-1:0] e0;
    logic [XLEN-1:0] e1;
    logic [NREGS-1:0] ebusy;
  } vec_t;

  vec_t vecs [12];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_total++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic logic [XLEN-1:0] lane(input int k);
    return rd_data[k*XLEN +: XLEN];
  endfunction

  function automatic logic [XLEN-1:0] m_read(input logic [AW-1:0] a);
    if (!m_ready || a == '0) return '0;
`ifdef RF_BYPASS_EN
    if (wr_en && wr_addr != '0 && a == wr_addr) return wr_data;
`endif
    return m_rf[a];
  endfunction

  // Advance the model by one clock using the inputs currently applied, then
  // let the DUT take the same edge and sample 1 time unit later.
  task automatic tick();
    if (reset) begin
      m_ready = 1'b0;
      m_swept = 0;
      m_busy  = '0;
    end else if (!m_ready) begin
      m_rf[m_swept] = (m_swept == SP_IDX) ? SP_INIT : '0;
      m_swept++;
      if (m_swept == NREGS) m_ready = 1'b1;
    end else begin
      if (wr_en && wr_addr != '0) begin
        m_rf[wr_addr]  = wr_data;
        m_busy[wr_addr] = 1'b0;
      end
      if (claim_en && claim_addr != '0) m_busy[claim_addr] = 1'b1;
    end
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    wr_en      = 1'b0;
    wr_addr    = '0;
    wr_data    = '0;
    claim_en   = 1'b0;
    claim_addr = '0;
  endtask

  task automatic set_rd(input logic [AW-1:0] a0, input logic [AW-1:0] a1);
    rd_addr = {a1, a0};
  endtask

  initial begin
    for (int i = 0; i < NREGS; i++) m_rf[i] = '0;
    m_busy  = '0;
    m_ready = 1'b0;
    m_swept = 0;

    vecs[0]  = '{1'b1, 5'd5, 32'hDEADBEEF, 1'b0, 5'd0, 5'd2, 5'd0, 32'h2ffc,     32'h0,        32'h0};
    vecs[1]  = '{1'b0, 5'd0, 32'h0,        1'b0, 5'd0, 5'd5, 5'd5, 32'hDEADBEEF, 32'hDEADBEEF, 32'h0};
    vecs[2]  = '{1'b1, 5'd0, 32'h1234,     1'b0, 5'd0, 5'd5, 5'd2, 32'hDEADBEEF, 32'h2ffc,     32'h0};
    vecs[3]  = '{1'b0, 5'd0, 32'h0,        1'b1, 5'd7, 5'd0, 5'd0, 32'h0,        32'h0,        32'h80};
    vecs[4]  = '{1'b0, 5'd0, 32'h0,        1'b0, 5'd0, 5'd7, 5'd7, 32'h0,        32'h0,        32'h80};
    vecs[5]  = '{1'b0, 5'd0, 32'h0,        1'b0, 5'd0, 5'd1, 5'd3, 32'h0,        32'h0,        32'h80};
    vecs[6]  = '{1'b1, 5'd7, 32'h55,       1'b0, 5'd0, 5'd5, 5'd6, 32'hDEADBEEF, 32'h0,        32'h0};
    vecs[7]  = '{1'b0, 5'd0, 32'h0,        1'b0, 5'd0, 5'd7, 5'd0, 32'h55,       32'h0,        32'h0};
    vecs[8]  = '{1'b1, 5'd7, 32'h55,       1'b1, 5'd7, 5'd5, 5'd2, 32'hDEADBEEF, 32'h2ffc,     32'h80};
    vecs[9]  = '{1'b1, 5'd7, 32'h77,       1'b1, 5'd4, 5'd4, 5'd5, 32'h0,        32'hDEADBEEF, 32'h10};
    vecs[10] = '{1'b1, 5'd6, 32'h66,       1'b1, 5'd4, 5'd7, 5'd0, 32'h77,       32'h0,        32'h10};
    vecs[11] = '{1'b0, 5'd0, 32'h0,        1'b1, 5'd0, 5'd6, 5'd4, 32'h66,       32'h0,        32'h10};

    // Reset held for 3 cycles.
    reset = 1'b1;
    idle();
    set_rd(5'd2, 5'd2);
    for (int i = 0; i < 3; i++) tick();
    check("reset_ready", 64'(ready), 64'd0);
    check("reset_busy", 64'(busy), 64'd0);
    check("reset_rd_lane0", 64'(lane(0)), 64'd0);

    // Start a sweep, then interrupt it with a 1-cycle reset at edge 10.
    reset = 1'b0;
    for (int e = 1; e <= 10; e++) begin
      tick();
      check("sweep1_ready", 64'(ready), 64'd0);
    end
    reset = 1'b1;
    tick();
    check("midreset_ready", 64'(ready), 64'd0);
    reset = 1'b0;

    // Restarted sweep; x3 is written and claimed after the sweep covered it.
    for (int e = 1; e <= NREGS; e++) begin
      if (e >= 5 && e <= 8) begin
        wr_en = 1'b1; wr_addr = 5'd3; wr_data = 32'hFF;
        claim_en = 1'b1; claim_addr = 5'd3;
      end else begin
        idle();
      end
      set_rd(5'd2, 5'd3);
      #1;
      check("sweep_rd_zero", 64'(lane(0)), 64'd0);
      tick();
      check($sformatf("sweep2_ready_e%0d", e), 64'(ready), (e == NREGS) ? 64'd1 : 64'd0);
      check("sweep2_busy", 64'(busy), 64'd0);
    end
    idle();

    // Post-init contents: only SP holds SP_INIT, x3 stayed 0.
    for (int r = 0; r < NREGS; r++) begin
      set_rd(AW'(r), AW'(r));
      #1;
      check($sformatf("init_x%0d_l0", r), 64'(lane(0)), (r == SP_IDX) ? 64'h2ffc : 64'd0);
      check($sformatf("init_x%0d_l1", r), 64'(lane(1)), (r == SP_IDX) ? 64'h2ffc : 64'd0);
    end
    check("init_busy", 64'(busy), 64'd0);
    check("init_busy3", 64'(busy[3]), 64'd0);

    // Table-driven RUN vectors: reads checked before the edge, busy after.
    for (int i = 0; i < 12; i++) begin
      wr_en = vecs[i].we; wr_addr = vecs[i].wa; wr_data = vecs[i].wd;
      claim_en = vecs[i].ce; claim_addr = vecs[i].ca;
      set_rd(vecs[i].ra0, vecs[i].ra1);
      #1;
      check($sformatf("vec%0d_rd0", i), 64'(lane(0)), 64'(vecs[i].e0));
      check($sformatf("vec%0d_rd1", i), 64'(lane(1)), 64'(vecs[i].e1));
      tick();
      check($sformatf("vec%0d_busy", i), 64'(busy), 64'(vecs[i].ebusy));
    end
    idle();

    // Same-cycle write and read of x9.
    wr_en = 1'b1; wr_addr = 5'd9; wr_data = 32'hA5A5A5A5;
    set_rd(5'd5, 5'd9);
    #1;
`ifdef RF_BYPASS_EN
    check("bypass_same_cycle", 64'(lane(1)), 64'hA5A5A5A5);
`else
    check("nobypass_same_cycle", 64'(lane(1)), 64'd0);
`endif
    check("bypass_lane0", 64'(lane(0)), 64'hDEADBEEF);
    tick();
    idle();
    #1;
    check("bypass_next_cycle", 64'(lane(1)), 64'hA5A5A5A5);

    // Randomized traffic against the model, with occasional resets.
    for (int c = 0; c < 600; c++) begin
      reset      = ($urandom_range(0, 199) == 0);
      wr_en      = $urandom_range(0, 1);
      wr_addr    = AW'($urandom_range(0, NREGS - 1));
      wr_data    = $urandom;
      claim_en   = $urandom_range(0, 1);
      claim_addr = ($urandom_range(0, 3) == 0) ? wr_addr : AW'($urandom_range(0, NREGS - 1));
      set_rd(($urandom_range(0, 3) == 0) ? wr_addr : AW'($urandom_range(0, NREGS - 1)),
             AW'($urandom_range(0, NREGS - 1)));
      #1;
      check("rand_rd0", 64'(lane(0)), 64'(m_read(rd_addr[0 +: AW])));
      check("rand_rd1", 64'(lane(1)), 64'(m_read(rd_addr[AW +: AW])));
      tick();
      check("rand_ready", 64'(ready), 64'(m_ready));
      check("rand_busy", 64'(busy), 64'(m_busy));
    end

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule
